mem_port_arbiter: RTL and testbench

- Shares one word-addressed data memory port between two requesters: the instruction-fetch port (read-only) and the data port (read/write with byte enables).
- Sits between the core's fetch/load-store units and the memory. Per-requester stall signals freeze the pipeline while a request is pending.
- Data has priority over fetch, with a bounded streak so that fetch is never starved.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [1:0] CNT_INIT   = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic        owner_d;
  logic [3:0]  streak;
  logic [1:0]  cnt;
  logic        grant_d, grant_f, zero_be;

  always_comb begin
    grant_d  = d_req && (!if_req || (streak != STREAK_MAX));
    grant_f  = if_req && !grant_d;
    zero_be  = grant_d && d_rw && (d_be == 4'h0);
    state_nx = state;
    case (state)
      IDLE: begin
        if (zero_be)                state_nx = RESP;
        else if (grant_d || grant_f) state_nx = ISSUE;
      end
      ISSUE:   state_nx = mem_rw ? RESP : WAIT;
      WAIT:    if (cnt == 2'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      streak    <= 4'd0;
      owner_d   <= 1'b1;
      cnt       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_f) begin
            owner_d <= grant_d;
            // Streak only grows while fetch is actually waiting behind data.
            if (grant_d && if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
            else
              streak <= 4'd0;
            if (!zero_be) begin
              mem_cs    <= 1'b1;
              mem_rw    <= grant_d && d_rw;
              mem_addr  <= grant_d ? d_addr : if_addr;
              mem_wdata <= grant_d ? d_wdata : 32'h0;
              mem_be    <= (grant_d && d_rw) ? d_be : 4'hF;
            end
          end
        end
        ISSUE: begin
          mem_cs <= 1'b0;
          cnt    <= CNT_INIT;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (owner_d) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_valid = (state == RESP) && !owner_d;
  assign d_valid  = (state == RESP) && owner_d;
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a 2-cycle memory model
module tb_mem_port_arbiter;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_valid, if_stall;
  logic          d_req = 1'b0;
  logic          d_rw = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [3:0]    d_be = 4'h0;
  logic [31:0]   d_rdata;
  logic          d_valid, d_stall;
  logic          mem_cs, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .READ_LATENCY(2), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  logic [1:0]  pv = 2'b00;
  logic [31:0] pd0 = '0, pd1 = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'h8C010004 : 32'h1000_0000 + 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_cs && mem_rw) begin
      mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_be);
    end
    pv  <= {pv[0], mem_cs && !mem_rw};
    pd0 <= mem[mem_addr[7:0]];
    pd1 <= pd0;
  end
  assign mem_rdata = pv[1] ? pd1 : 32'hDEAD_BEEF;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cs_log[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_d_rdata = '0;

  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        n_tests++;
        if (if_valid && d_valid) begin
          n_fail++; $display("FAIL both_valid got if_valid=%b d_valid=%b exp one-hot", if_valid, d_valid);
        end
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_valid at cycle %0d got if_valid=%b d_valid=%b exp none", cyc, if_valid, d_valid);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (d_valid !== e.is_data) begin
            n_fail++; $display("FAIL grant_port at cycle %0d got d_valid=%b exp %b", cyc, d_valid, e.is_data);
          end
          got = e.is_data ? d_rdata : if_rdata;
          n_tests++;
          if (got !== e.rdata) begin
            n_fail++; $display("FAIL rdata at cycle %0d got %h exp %h", cyc, got, e.rdata);
          end
          n_tests++;
          if (cyc !== e.due) begin
            n_fail++; $display("FAIL latency got cycle %0d exp cycle %0d", cyc, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (mem_cs) cs_log.push_back(cyc);
  endtask

  task automatic rel();
    if (if_valid) if_req = 1'b0;
    if (d_valid)  d_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_cs, mem_rw, mem_be} !== 6'h0) begin
      n_fail++; $display("FAIL reset_ctrl got cs=%b rw=%b be=%h exp 0", mem_cs, mem_rw, mem_be);
    end
    n_tests++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
    end
    n_tests++;
    if ({if_valid, d_valid, if_stall, d_stall} !== 4'h0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0000", {if_valid, d_valid, if_stall, d_stall});
    end
    n_tests++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h %h exp 0", if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_read();
    int c;
    @(negedge clk);
    c = cyc;
    cs_log.delete();
    if_req = 1'b1; if_addr = 30'h10;
    sb.push_back('{is_data: 1'b0, rdata: 32'h8C010004, due: c + 4});
    #1;
    n_tests++;
    if (if_stall !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_c got %b exp 1", if_stall);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      tick();
      n_tests++;
      if (if_stall !== (cyc < c + 4)) begin
        n_fail++; $display("FAIL fetch_stall cycle %0d got %b exp %b", cyc - c, if_stall, (cyc < c + 4));
      end
      if (cyc == c + 1) begin
        n_tests++;
        if ({mem_rw, mem_be, mem_addr} !== {1'b0, 4'hF, 30'h10}) begin
          n_fail++; $display("FAIL fetch_issue got rw=%b be=%h addr=%h exp 0 f 10", mem_rw, mem_be, mem_addr);
        end
      end
      rel();
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL fetch_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 1 || cs_log[0] != c + 1) begin
      n_fail++; $display("FAIL fetch_cs got %0d pulses exp 1 at c+1", cs_log.size());
    end
  endtask

  task automatic test_byte_write();
    int c;
    @(negedge clk);
    c = cyc;
    cs_log.delete();
    d_req = 1'b1; d_rw = 1'b1; d_be = 4'b0100; d_wdata = 32'h00AB0000; d_addr = 30'h3;
    sb.push_back('{is_data: 1'b1, rdata: exp_d_rdata, due: c + 2});
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      tick();
      if (cyc == c + 1) begin
        n_tests++;
        if ({mem_cs, mem_rw, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0100, 30'h3, 32'h00AB0000}) begin
          n_fail++; $display("FAIL bwrite_issue got cs=%b rw=%b be=%b addr=%h wd=%h exp 1 1 0100 3 00ab0000",
                             mem_cs, mem_rw, mem_be, mem_addr, mem_wdata);
        end
      end
      rel();
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL bwrite_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 1) begin
      n_fail++; $display("FAIL bwrite_cs got %0d pulses exp 1", cs_log.size());
    end
    n_tests++;
    if (mem[3] !== 32'h10AB0003) begin
      n_fail++; $display("FAIL bwrite_mem got %h exp 10ab0003", mem[3]);
    end
  endtask

  task automatic test_zero_be();
    int c;
    @(negedge clk);
    c = cyc;
    cs_log.delete();
    d_req = 1'b1; d_rw = 1'b1; d_be = 4'h0; d_wdata = 32'hFFFF_FFFF; d_addr = 30'h5;
    sb.push_back('{is_data: 1'b1, rdata: exp_d_rdata, due: c + 1});
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      tick();
      rel();
    end
    repeat (2) tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL zbe_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 0) begin
      n_fail++; $display("FAIL zbe_cs got %0d pulses exp 0", cs_log.size());
    end
    n_tests++;
    if (mem[5] !== 32'h1000_0005) begin
      n_fail++; $display("FAIL zbe_mem got %h exp 10000005", mem[5]);
    end
  endtask

  task automatic test_starvation();
    int t;
    @(negedge clk);
    t = cyc;
    cs_log.delete();
    if_req = 1'b1; if_addr = 30'h10;
    d_req = 1'b1; d_rw = 1'b1; d_be = 4'hF; d_wdata = 32'hCAFE_F00D; d_addr = 30'h20;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        sb.push_back('{is_data: 1'b1, rdata: exp_d_rdata, due: t + 2});
        t += 3;
      end
      sb.push_back('{is_data: 1'b0, rdata: 32'h8C010004, due: t + 4});
      t += 5;
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    if_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL starve_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 10) begin
      n_fail++; $display("FAIL starve_cs got %0d pulses exp 10", cs_log.size());
    end
    n_tests++;
    if (mem[32] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL starve_mem got %h exp cafef00d", mem[32]);
    end
  endtask

  task automatic test_simultaneous();
    int c;
    @(negedge clk);
    c = cyc;
    cs_log.delete();
    if_req = 1'b1; if_addr = 30'h10;
    d_req = 1'b1; d_rw = 1'b0; d_be = 4'b0011; d_addr = 30'h3;
    sb.push_back('{is_data: 1'b1, rdata: 32'h10AB0003, due: c + 4});
    sb.push_back('{is_data: 1'b0, rdata: 32'h8C010004, due: c + 9});
    exp_d_rdata = 32'h10AB0003;
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      tick();
      if (cyc == c + 1) begin
        n_tests++;
        if ({mem_rw, mem_be, mem_addr} !== {1'b0, 4'hF, 30'h3}) begin
          n_fail++; $display("FAIL sim_dread_issue got rw=%b be=%h addr=%h exp 0 f 3", mem_rw, mem_be, mem_addr);
        end
      end
      rel();
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sim_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 2 || cs_log[0] != c + 1 || cs_log[1] != c + 6) begin
      n_fail++; $display("FAIL sim_cs got %0d pulses exp 2 at c+1,c+6", cs_log.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int c, r;
    @(negedge clk);
    c = cyc;
    if_req = 1'b1; if_addr = 30'h11;
    tick();
    tick();
    rst_n = 1'b0;
    exp_d_rdata = '0;
    #1;
    n_tests++;
    if ({mem_cs, if_valid, d_valid, if_stall} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_mid_outs got cs=%b ifv=%b dv=%b ifst=%b exp 0 0 0 1", mem_cs, if_valid, d_valid, if_stall);
    end
    n_tests++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_rdata got %h %h exp 0", if_rdata, d_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    cs_log.delete();
    sb.push_back('{is_data: 1'b0, rdata: 32'h1000_0011, due: r + 4});
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      tick();
      rel();
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_timeout got %0d pending exp 0", sb.size()); sb.delete();
    end
    n_tests++;
    if (cs_log.size() != 1 || cs_log[0] != r + 1) begin
      n_fail++; $display("FAIL rst_mid_cs got %0d pulses exp 1 at r+1 (c=%0d)", cs_log.size(), c);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_byte_write();
    test_zero_be();
    test_starvation();
    test_simultaneous();
    test_reset_mid_read();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
